// File: rtl/pc_update_unit_pkg.sv
// Shared constants for the PC update stage: next-PC source encodings and reset vector.
package pc_update_unit_pkg;

    localparam int unsigned PC_SRC_W      = 2;
    localparam int unsigned INSTR_INDEX_W = 26;
    localparam int unsigned COUNT_W       = 32;

    localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [PC_SRC_W-1:0] PC_SRC_REG    = 2'd3;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/pc_update_unit_if.sv
// Control/data bundle between the multicycle controller and the PC update stage.
interface pc_update_unit_if
    import pc_update_unit_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 32
);
    logic [WORD_LENGTH-1:0]   sign_ext_shifted;
    logic [INSTR_INDEX_W-1:0] instr_index;
    logic [WORD_LENGTH-1:0]   reg_target;
    logic                     zero;
    logic                     target_load;
    logic                     pc_write;
    logic                     pc_write_cond;
    logic                     branch_ne;
    logic [PC_SRC_W-1:0]      pc_src;
    logic [WORD_LENGTH-1:0]   pc;
    logic [WORD_LENGTH-1:0]   pc_plus4;
    logic [WORD_LENGTH-1:0]   branch_target;
    logic                     branch_taken;
    logic [COUNT_W-1:0]       branch_count;

    modport master (
        output sign_ext_shifted, instr_index, reg_target, zero, target_load,
               pc_write, pc_write_cond, branch_ne, pc_src,
        input  pc, pc_plus4, branch_target, branch_taken, branch_count
    );

    modport slave (
        input  sign_ext_shifted, instr_index, reg_target, zero, target_load,
               pc_write, pc_write_cond, branch_ne, pc_src,
        output pc, pc_plus4, branch_target, branch_taken, branch_count
    );
endinterface

// File: rtl/pc_update_unit_pc_next_mux.sv
// Combinational 4:1 next-PC select, including J-type and JR target formatting.
module pc_next_mux
    import pc_update_unit_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 32
) (
    input  logic [PC_SRC_W-1:0]      pc_src,
    input  logic [WORD_LENGTH-1:0]   pc_plus4,
    input  logic [WORD_LENGTH-1:0]   branch_target,
    input  logic [WORD_LENGTH-29:0]  pc_hi,
    input  logic [INSTR_INDEX_W-1:0] instr_index,
    input  logic [WORD_LENGTH-1:0]   reg_target,
    output logic [WORD_LENGTH-1:0]   next_pc_c
);

    localparam logic [WORD_LENGTH-1:0] WORD_ALIGN_MASK = ~WORD_LENGTH'(3);

    always_comb begin
        next_pc_c = pc_plus4;
        case (pc_src)
            PC_SRC_SEQ:    next_pc_c = pc_plus4;
            PC_SRC_BRANCH: next_pc_c = branch_target;
            PC_SRC_JUMP:   next_pc_c = {pc_hi, instr_index, 2'b00};
            PC_SRC_REG:    next_pc_c = reg_target & WORD_ALIGN_MASK;
            default:       next_pc_c = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// PC and branch-target registers with conditional PC write for the multicycle MIPS datapath.
// Optional taken-branch counter enabled by defining BRANCH_COUNT_EN.
module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter int unsigned            WORD_LENGTH  = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_VECTOR = WORD_LENGTH'(RESET_VECTOR_DEFAULT)
) (
    input logic             clk,
    input logic             reset,
    pc_update_unit_if.slave bus
);

    localparam logic [WORD_LENGTH-1:0] PC_STEP = WORD_LENGTH'(4);

    logic [WORD_LENGTH-1:0] pc_q, pc_d;
    logic [WORD_LENGTH-1:0] branch_target_q, branch_target_d;
    logic                   branch_taken_q, branch_taken_d;
    logic [WORD_LENGTH-1:0] pc_plus4_c;
    logic [WORD_LENGTH-1:0] next_pc_c;
    logic                   cond_c;
    logic                   pc_update_c;

    assign pc_plus4_c = pc_q + PC_STEP;

    pc_next_mux #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_pc_next_mux (
        .pc_src        (bus.pc_src),
        .pc_plus4      (pc_plus4_c),
        .branch_target (branch_target_q),
        .pc_hi         (pc_q[WORD_LENGTH-1:28]),
        .instr_index   (bus.instr_index),
        .reg_target    (bus.reg_target),
        .next_pc_c     (next_pc_c)
    );

    // BEQ takes on zero, BNE on not-zero; an unconditional write masks the branch pulse.
    always_comb begin
        cond_c          = bus.zero ^ bus.branch_ne;
        pc_update_c     = bus.pc_write | (bus.pc_write_cond & cond_c);
        pc_d            = pc_q;
        branch_target_d = branch_target_q;
        branch_taken_d  = bus.pc_write_cond & cond_c & ~bus.pc_write;
        if (pc_update_c) begin
            pc_d = next_pc_c;
        end
        if (bus.target_load) begin
            branch_target_d = pc_q + bus.sign_ext_shifted;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q            <= RESET_VECTOR;
            branch_target_q <= '0;
            branch_taken_q  <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            branch_target_q <= branch_target_d;
            branch_taken_q  <= branch_taken_d;
        end
    end

`ifdef BRANCH_COUNT_EN
    logic [COUNT_W-1:0] branch_count_q, branch_count_d;

    // Counts on the edge that raises branch_taken, saturating at all-ones.
    always_comb begin
        branch_count_d = branch_count_q;
        if (branch_taken_d && (branch_count_q != {COUNT_W{1'b1}})) begin
            branch_count_d = branch_count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count_q <= '0;
        end else begin
            branch_count_q <= branch_count_d;
        end
    end

    assign bus.branch_count = branch_count_q;
`else
    assign bus.branch_count = '0;
`endif

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4_c;
    assign bus.branch_target = branch_target_q;
    assign bus.branch_taken  = branch_taken_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed plus randomized bench for pc_update_unit against a behavioural PC model.
module tb_pc_update_unit;
    import pc_update_unit_pkg::*;

    localparam int unsigned W  = 32;
    localparam logic [31:0] RV = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] m_pc, m_tgt, m_cnt;
    logic        m_taken;

    pc_update_unit_if #(.WORD_LENGTH(W)) bus ();

    pc_update_unit #(
        .WORD_LENGTH  (W),
        .RESET_VECTOR (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, bus.pc, m_pc);
        chk({tag, ".pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
        chk({tag, ".target"}, bus.branch_target, m_tgt);
        chk({tag, ".taken"}, 32'(bus.branch_taken), 32'(m_taken));
        chk({tag, ".count"}, bus.branch_count, m_cnt);
    endtask

    task automatic model_reset();
        m_pc    = RV;
        m_tgt   = 32'd0;
        m_taken = 1'b0;
        m_cnt   = 32'd0;
    endtask

    task automatic drive(input logic pw, input logic pwc, input logic z, input logic bne,
                         input logic tl, input logic [1:0] src, input logic [31:0] ses,
                         input logic [31:0] rt, input logic [25:0] idx);
        bus.pc_write         = pw;
        bus.pc_write_cond    = pwc;
        bus.zero             = z;
        bus.branch_ne        = bne;
        bus.target_load      = tl;
        bus.pc_src           = src;
        bus.sign_ext_shifted = ses;
        bus.reg_target       = rt;
        bus.instr_index      = idx;
    endtask

    // One clock edge: derive the architectural outcome from the current inputs, then compare.
    task automatic step(input string tag);
        logic [31:0] target_pc, new_pc, new_tgt;
        logic        take, new_taken;
        take = (bus.branch_ne == 1'b0) ? bus.zero : !bus.zero;
        if (bus.pc_src == 2'd0)      target_pc = m_pc + 32'd4;
        else if (bus.pc_src == 2'd1) target_pc = m_tgt;
        else if (bus.pc_src == 2'd2) target_pc = (m_pc & 32'hF000_0000) | (32'(bus.instr_index) * 32'd4);
        else                         target_pc = (bus.reg_target / 32'd4) * 32'd4;
        new_pc    = (bus.pc_write || (bus.pc_write_cond && take)) ? target_pc : m_pc;
        new_tgt   = bus.target_load ? m_pc + bus.sign_ext_shifted : m_tgt;
        new_taken = bus.pc_write_cond && take && !bus.pc_write;
        @(posedge clk);
        #1;
        m_pc    = new_pc;
        m_tgt   = new_tgt;
        m_taken = new_taken;
`ifdef BRANCH_COUNT_EN
        if (new_taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
        chk_all(tag);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PC_SRC_SEQ, 32'd0, 32'd0, 26'd0);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset_hold");

        reset = 1'b1;
        step("fetch1");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, PC_SRC_SEQ, 32'hFFFF_FFF8, 32'd0, 26'd0);
        step("fetch2_tload");
        chk("fetch2_pc_abs", bus.pc, 32'h0040_0008);
        chk("tgt_neg_abs", bus.branch_target, 32'h003F_FFFC);

        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, PC_SRC_BRANCH, 32'd0, 32'd0, 26'd0);
        step("beq_taken");
        chk("beq_pc_abs", bus.pc, 32'h003F_FFFC);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PC_SRC_SEQ, 32'd0, 32'd0, 26'd0);
        step("beq_pulse_end");

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, PC_SRC_SEQ, 32'h0000_0100, 32'd0, 26'd0);
        step("tload_fwd");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, PC_SRC_BRANCH, 32'd0, 32'd0, 26'd0);
        step("bne_not_taken");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, PC_SRC_BRANCH, 32'd0, 32'd0, 26'd0);
        step("bne_taken");
        chk("bne_pc_abs", bus.pc, 32'h0040_00FC);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PC_SRC_REG, 32'd0, 32'h8040_0010, 26'd0);
        step("jr_setup");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PC_SRC_JUMP, 32'd0, 32'd0, 26'h000_0100);
        step("jump");
        chk("jump_pc_abs", bus.pc, 32'h8000_0400);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PC_SRC_REG, 32'd0, 32'h0040_0123, 26'd0);
        step("jr_align");
        chk("jr_pc_abs", bus.pc, 32'h0040_0120);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PC_SRC_SEQ, 32'd0, 32'd0, 26'd0);
        step("pw_overrides");
        chk("pw_overrides_abs", bus.pc, 32'h0040_0124);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PC_SRC_REG, 32'd0, 32'hFFFF_FFFC, 26'd0);
        step("wrap_setup");
        chk("plus4_wrap", bus.pc_plus4, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PC_SRC_SEQ, 32'd0, 32'd0, 26'd0);
        step("wrap");
        chk("wrap_abs", bus.pc, 32'd0);

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, PC_SRC_BRANCH, 32'd0, 32'd0, 26'd0);
            step("count_branch");
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PC_SRC_SEQ, 32'd0, 32'd0, 26'd0);
            step("count_idle");
        end

        // Asynchronous reset in the middle of a pending write.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, PC_SRC_SEQ, 32'h10, 32'd0, 26'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        @(posedge clk);
        #1;
        chk_all("reset_edge_hold");
        reset = 1'b1;
        step("after_reset");

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 2'($urandom), $urandom, $urandom, 26'($urandom));
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Program-counter stage of the multicycle MIPS datapath, directly downstream of the branch-offset shifter.
- Consumes the shifted sign-extended offset and forms the branch target.
- Holds the PC and branch-target registers and selects the next PC from four sources: sequential, branch, jump and register.
- Applies unconditional and conditional (BEQ/BNE) PC writes under control of the multicycle control FSM.

Parameters:
- WORD_LENGTH, 32, datapath width. Must be >= 32.
- RESET_VECTOR, 32'h0040_0000, PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sign_ext_shifted  input  WORD_LENGTH  branch offset already shifted left by 2.
- instr_index  input  26  instruction[25:0], used as the J/JAL target index.
- reg_target  input  WORD_LENGTH  register value used by JR.
- zero  input  1  ALU zero flag.
- target_load  input  1  capture the branch target (decode state).
- pc_write  input  1  unconditional PC update.
- pc_write_cond  input  1  conditional PC update (branch state).
- branch_ne  input  1  0 = BEQ condition, 1 = BNE condition.
- pc_src  input  2  next-PC select.
- pc  output  WORD_LENGTH  current PC.
- pc_plus4  output  WORD_LENGTH  pc + 4, combinational.
- branch_target  output  WORD_LENGTH  registered branch target.
- branch_taken  output  1  one-cycle pulse after a taken conditional branch.
- branch_count  output  32  taken-branch count (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-low. While reset is low:
  - pc = RESET_VECTOR
  - branch_target = 0
  - branch_taken = 0
  - branch_count = 0
- Reset asserted mid-operation aborts any pending update immediately. The first rising edge after release uses normal rules.
- pc_plus4 = pc + 4, modulo 2^WORD_LENGTH. 32'hFFFF_FFFC wraps to 0.
- Target capture: on a rising edge with target_load = 1, branch_target <= pc + sign_ext_shifted, modulo 2^WORD_LENGTH. Negative offsets come from two's-complement addition.
- Next-PC select (next_pc):
  - pc_src 0: pc_plus4
  - pc_src 1: branch_target
  - pc_src 2: {pc[31:28], instr_index, 2'b00}
  - pc_src 3: {reg_target[W-1:2], 2'b00}; the low bits are forced to 0.
- Condition cond = zero XOR branch_ne.
- PC update: pc <= next_pc on a rising edge when pc_write = 1, or when pc_write_cond = 1 and cond = 1. Otherwise pc holds. Latency is one edge.
- pc_write = 1 overrides the condition: the update happens regardless of zero or pc_write_cond.
- If target_load and a PC update occur on the same edge, the target is computed from the old pc.
- branch_taken <= pc_write_cond AND cond AND NOT pc_write. It is a registered pulse, high for exactly one cycle per taken branch.
- No internal FSM. The sequence is driven by the controller: fetch (pc_write, src 0), decode (target_load), branch (pc_write_cond, src 1), jump (pc_write, src 2/3).

Optional Feature:
- Macro: BRANCH_COUNT_EN.
- Defined: a 32-bit counter increments on every edge where branch_taken is set. It saturates at 32'hFFFF_FFFF and is cleared by reset. The value is driven on branch_count.
- Undefined: no counter is synthesised and branch_count is tied to 0.

Decomposition:
- Shared package: PC_SRC_SEQ = 2'd0, PC_SRC_BRANCH = 2'd1, PC_SRC_JUMP = 2'd2, PC_SRC_REG = 2'd3, plus the RESET_VECTOR default.
- One natural sub-module, pc_next_mux: purely combinational 4:1 next-PC select including jump and JR formatting.
- Registers, condition logic and the counter stay in the top module.

Test Plan:
- Reset low for 3 cycles, then release:
  - During reset, pc = 32'h0040_0000, branch_target = 0, branch_taken = 0, even if pc_write is asserted during reset.
  - After release, pc_write = 1 with src 0 for 2 edges -> pc = 32'h0040_0008.
- pc = 32'h0040_0004, target_load = 1, sign_ext_shifted = 32'hFFFF_FFF8:
  - branch_target = 32'h0040_FFFC? No; the correct result is 32'h003F_FFFC.
  - Then BEQ with pc_write_cond = 1, zero = 1, src 1 -> pc = 32'h003F_FFFC and branch_taken high for one cycle.
- BNE: pc_write_cond = 1, branch_ne = 1, zero = 1 -> pc unchanged, branch_taken stays 0. With zero = 0 -> pc is updated.
- Jump: pc = 32'h8040_0010, instr_index = 26'h000_0100, src 2, pc_write -> pc = 32'h8000_0400.
- JR: reg_target = 32'h0040_0123, src 3 -> pc = 32'h0040_0120.
- Simultaneous and boundary cases:
  - pc_write = 1 and pc_write_cond = 1 with zero = 0 -> pc updates, branch_taken stays 0.
  - pc = 32'hFFFF_FFFC with src 0 -> pc = 0.
  - With BRANCH_COUNT_EN: 5 taken branches -> branch_count = 5.
